// File: rtl/onehot_dwell_decoder.sv
// onehot_dwell_decoder: queues (code, dwell) commands and drives 1<<code on out for max(dwell,1) cycles each.
// Latency: command pushed into an empty queue while idle appears on out one edge later; patterns chain back-to-back.
// Backpressure: in_ready = !full of the command FIFO; a pop never frees a slot for a same-edge push.
// Build option: define ONEHOT_DWELL_GAP_EN to insert one all-zero cycle between consecutive patterns.

// Generic circular-buffer FIFO with occupancy output; DEPTH must be a power of two.
module onehot_dwell_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld,
    output logic          push_rdy,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic          pop_vld,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   level
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          push;
    logic          pop;

    // Full/empty come straight from the occupancy counter so readiness never depends on a pop.
    always_comb begin
        push_rdy = (cnt_q != (AW+1)'(DEPTH));
        pop_vld  = (cnt_q != '0);
        push     = push_vld && push_rdy;
        pop      = pop_rdy && pop_vld;
        pop_dat  = mem_q[rd_ptr_q];
        level    = cnt_q;
    end

    // Storage array: written on push only, no reset needed since reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy holds on simultaneous push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

module onehot_dwell_decoder #(
    parameter  int CODE_W  = 3,
    parameter  int DEPTH   = 4,
    parameter  int DWELL_W = 8,
    localparam int N       = 2**CODE_W,
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CODE_W-1:0]  in_code,
    input  logic [DWELL_W-1:0] in_dwell,
    output logic [N-1:0]       out,
    output logic               out_active,
    output logic               out_done,
    output logic [LVL_W-1:0]   level
);

    typedef struct packed {
        logic [CODE_W-1:0]  code;
        logic [DWELL_W-1:0] dwell;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1
`ifdef ONEHOT_DWELL_GAP_EN
        ,
        GAP   = 2'd2
`endif
    } state_t;

    state_t             state_q;
    logic [N-1:0]       out_q;
    logic               out_active_q;
    logic               out_done_q;
    logic [DWELL_W-1:0] cnt_q;

    cmd_t               push_cmd;
    cmd_t               head_cmd;
    logic               head_vld;
    logic               take;
    logic [N-1:0]       out_d;
    logic [DWELL_W-1:0] cnt_d;
    logic               done_d;

    assign push_cmd = '{code: in_code, dwell: in_dwell};

    onehot_dwell_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (push_cmd),
        .pop_rdy  (take),
        .pop_vld  (head_vld),
        .pop_dat  (head_cmd),
        .level    (level)
    );

    // Decide whether the head command is consumed on this edge and precompute its load values.
    always_comb begin
`ifdef ONEHOT_DWELL_GAP_EN
        // A finishing pattern always passes through GAP, so only IDLE/GAP may pop.
        take = head_vld && ((state_q == IDLE) || (state_q == GAP));
`else
        take = head_vld && ((state_q == IDLE) || ((state_q == DRIVE) && (cnt_q == '0)));
`endif
        out_d                = '0;
        out_d[head_cmd.code] = 1'b1;
        // Dwell 0 behaves as 1; the counter holds remaining cycles after the first.
        cnt_d  = (head_cmd.dwell == '0) ? '0 : head_cmd.dwell - DWELL_W'(1);
        done_d = (head_cmd.dwell <= DWELL_W'(1));
    end

    // Sequencer: loads a new pattern, counts its dwell down, and flags the last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_q        <= '0;
            out_active_q <= 1'b0;
            out_done_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_done_q <= 1'b0;
            if (take) begin
                state_q      <= DRIVE;
                out_q        <= out_d;
                out_active_q <= 1'b1;
                cnt_q        <= cnt_d;
                out_done_q   <= done_d;
            end else begin
                case (state_q)
                    DRIVE: begin
                        if (cnt_q != '0) begin
                            // Mid-dwell: pattern held, done raised for the final cycle.
                            cnt_q      <= cnt_q - DWELL_W'(1);
                            out_done_q <= (cnt_q == DWELL_W'(1));
                        end else begin
                            out_q        <= '0;
                            out_active_q <= 1'b0;
`ifdef ONEHOT_DWELL_GAP_EN
                            state_q      <= GAP;
`else
                            state_q      <= IDLE;
`endif
                        end
                    end
                    default: begin
                        out_q        <= '0;
                        out_active_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                endcase
            end
        end
    end

    assign out        = out_q;
    assign out_active = out_active_q;
    assign out_done   = out_done_q;

endmodule

// File: tb/tb_onehot_dwell_decoder.sv
// Bench for onehot_dwell_decoder: directed scenarios plus a random stream.
// Expected outputs come from a queue-plus-remaining-cycles model of the command timeline.
// Build with ONEHOT_DWELL_GAP_EN defined to cover the break-before-make variant.
module tb_onehot_dwell_decoder;

    localparam int DEPTH = 4;
`ifdef ONEHOT_DWELL_GAP_EN
    localparam bit GAP_MODE = 1'b1;
`else
    localparam bit GAP_MODE = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic [7:0] in_dwell;
    logic [7:0] out;
    logic       out_active;
    logic       out_done;
    logic [2:0] level;

    int total;
    int bad;

    typedef struct {
        int code;
        int dwell;
    } cmd_s;

    cmd_s       fq[$];
    int         rem;
    logic [7:0] cur;

    onehot_dwell_decoder #(
        .CODE_W  (3),
        .DEPTH   (DEPTH),
        .DWELL_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_dwell   (in_dwell),
        .out        (out),
        .out_active (out_active),
        .out_done   (out_done),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        rem = 0;
        cur = '0;
    endtask

    // rem = cycles of the current pattern still to show, counting the present one.
    task automatic model_edge(input bit push, input int code, input int dwell);
        cmd_s c;
        if (rem > 1) begin
            rem = rem - 1;
        end else if (rem == 1 && GAP_MODE) begin
            rem = 0;
            cur = '0;
        end else if (fq.size() > 0) begin
            c   = fq.pop_front();
            rem = (c.dwell == 0) ? 1 : c.dwell;
            cur = 8'd1 << c.code;
        end else begin
            rem = 0;
            cur = '0;
        end
        if (push) begin
            c.code  = code;
            c.dwell = dwell;
            fq.push_back(c);
        end
    endtask

    task automatic check_all();
        chk("out", 32'(out), (rem > 0) ? 32'(cur) : 32'd0);
        chk("out_active", 32'(out_active), (rem > 0) ? 32'd1 : 32'd0);
        chk("out_done", 32'(out_done), (rem == 1) ? 32'd1 : 32'd0);
        chk("level", 32'(level), 32'(fq.size()));
        chk("in_ready", 32'(in_ready), (fq.size() < DEPTH) ? 32'd1 : 32'd0);
        chk("onehot0", 32'($onehot0(out)), 32'd1);
    endtask

    // One clock: model advances on the edge, DUT is compared on the falling edge.
    task automatic cycle();
        bit push;
        int code;
        int dwell;
        push  = rst_n && in_valid && (fq.size() < DEPTH);
        code  = int'(in_code);
        dwell = int'(in_dwell);
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(push, code, dwell);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [7:0] exp2 [4];
        int  n_on;
        int  n_done;
        int  waited;
        bit  saw_low;
        bit  accepted;

        total = 0;
        bad   = 0;
        model_reset();

        // Reset with a command presented: it must be dropped.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_code  = 3'd6;
        in_dwell = 8'd4;
        repeat (3) cycle();
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (3) cycle();
        chk("post_reset_idle", 32'(out), 32'd0);

        // Test 1: code 5, dwell 3.
        in_valid = 1'b1; in_code = 3'd5; in_dwell = 8'd3;
        cycle();
        in_valid = 1'b0;
        cycle(); chk("t1_e1_out", 32'(out), 32'h20);
        cycle(); chk("t1_e2_out", 32'(out), 32'h20); chk("t1_e2_done", 32'(out_done), 32'd0);
        cycle(); chk("t1_e3_out", 32'(out), 32'h20); chk("t1_e3_done", 32'(out_done), 32'd1);
        cycle(); chk("t1_e4_out", 32'(out), 32'h0);  chk("t1_e4_active", 32'(out_active), 32'd0);
        chk("t1_e4_level", 32'(level), 32'd0);
        repeat (2) cycle();

        // Test 2: 0/0 then 7/2 on consecutive cycles.
        if (GAP_MODE) begin
            exp2[0] = 8'h01; exp2[1] = 8'h00; exp2[2] = 8'h80; exp2[3] = 8'h80;
        end else begin
            exp2[0] = 8'h01; exp2[1] = 8'h80; exp2[2] = 8'h80; exp2[3] = 8'h00;
        end
        in_valid = 1'b1; in_code = 3'd0; in_dwell = 8'd0;
        cycle();
        in_code = 3'd7; in_dwell = 8'd2;
        cycle();
        in_valid = 1'b0;
        chk("t2_c0", 32'(out), 32'(exp2[0]));
        for (int i = 1; i < 4; i++) begin
            cycle();
            chk("t2_seq", 32'(out), 32'(exp2[i]));
        end
        repeat (3) cycle();

        // Test 3: eight commands held valid against a depth-4 queue.
        saw_low = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_code  = 3'(i);
            in_dwell = 8'd10;
            accepted = 1'b0;
            waited   = 0;
            while (!accepted && waited < 200) begin
                accepted = (fq.size() < DEPTH);
                cycle();
                if (in_ready === 1'b0) saw_low = 1'b1;
                waited++;
            end
            if (!accepted) chk("t3_accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        chk("t3_ready_dropped", 32'(saw_low), 32'd1);
        repeat (100) cycle();
        chk("t3_drained", 32'(out), 32'd0);

        // Test 4: maximum dwell.
        in_valid = 1'b1; in_code = 3'd3; in_dwell = 8'd255;
        cycle();
        in_valid = 1'b0;
        n_on   = 0;
        n_done = 0;
        for (int i = 0; i < 262; i++) begin
            cycle();
            if (out === 8'h08) n_on++;
            if (out_done === 1'b1) n_done++;
        end
        chk("t4_on_cycles", 32'(n_on), 32'd255);
        chk("t4_done_pulses", 32'(n_done), 32'd1);

        // Test 5: asynchronous reset mid-dwell with three commands queued.
        in_valid = 1'b1;
        in_dwell = 8'd20;
        in_code  = 3'd1; cycle();
        in_code  = 3'd2; cycle();
        in_code  = 3'd4; cycle();
        in_code  = 3'd6; cycle();
        in_valid = 1'b0;
        repeat (2) cycle();
        chk("t5_queued", 32'(level), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_out", 32'(out), 32'd0);
        chk("t5_async_active", 32'(out_active), 32'd0);
        chk("t5_async_level", 32'(level), 32'd0);
        chk("t5_async_ready", 32'(in_ready), 32'd1);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            chk("t5_no_residual", 32'(out), 32'd0);
        end

        // Test 6: random stream.
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_code  = 3'($urandom_range(0, 7));
            in_dwell = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                                   : 8'($urandom_range(0, 4));
            cycle();
        end
        in_valid = 1'b0;
        repeat (250) cycle();
        chk("t6_drained_level", 32'(level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
